// File: rtl/disp_mode_ctrl.sv
// -----------------------------------------------------------------------------
// disp_mode_ctrl
//
// Phase sequencer and owner of the four-digit value bus that feeds the
// SevSeg_4digit driver. Three phases share the digits:
//   ENTRY    - the player programs a 4-digit target, one hex digit per write
//   RUN      - digits track the live 16-bit game counter
//   FINISHED - digits freeze on the final count, optionally blinking
// The programmed target is exported to the game logic. Every output is driven
// from a register (or is a constant), so input-to-output latency is one cycle.
//
// Optional feature macro: DISP_BLINK_EN
//   defined   - FINISHED blinks the whole display every BLINK_DIV cycles
//   undefined - no blink counter is built, blank is constant 4'b0000
//
// Parameters:
//   BLINK_DIV  clk cycles per blink half-period in FINISHED (>= 2)
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   wr_en      in   1   digit write strobe, honoured only in ENTRY
//   wr_loc     in   2   digit index for the write, 0 = rightmost
//   wr_value   in   4   hex value written to digit wr_loc
//   start      in   1   start the game (ENTRY -> RUN)
//   finish     in   1   end the game (RUN -> FINISHED)
//   clear      in   1   back to ENTRY, wipe entry digits and target
//   counter    in   16  live game counter
//   dig0..dig3 out  4   digit values to the display, dig0 = rightmost
//   blank      out  4   per-digit blank mask, 1 = dark
//   mode       out  2   phase (00 ENTRY, 01 RUN, 10 FINISHED); this is the
//                       FSM state register itself
//   target     out  16  programmed value {entry3,entry2,entry1,entry0}
//
// Handshake: start/finish/clear are level-sampled strobes with no ready
// return; holding one for several cycles repeats a no-op transition, so a
// long pulse behaves as a single event. Priority is clear > start > finish.
// -----------------------------------------------------------------------------
module disp_mode_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_loc,
  input  logic [3:0]  wr_value,
  input  logic        start,
  input  logic        finish,
  input  logic        clear,
  input  logic [15:0] counter,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  blank,
  output logic [1:0]  mode,
  output logic [15:0] target
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIN   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0][3:0]  r_entry;
  logic [3:0][3:0]  w_entry_next;
  logic [3:0][3:0]  r_dig;
  logic [3:0][3:0]  w_dig_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ENTRY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. clear overrides everything; 2'b11 recovers to ENTRY.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_ENTRY;
    end else begin
      case (r_state)
        ST_ENTRY: if (start)  w_state_next = ST_RUN;
        ST_RUN:   if (finish) w_state_next = ST_FIN;
        ST_FIN:   w_state_next = ST_FIN;
        default:  w_state_next = ST_ENTRY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry digits. A write in the same cycle as start still lands because the
  // write is qualified by the current state, not the next one.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_entry_next = r_entry;
    if (clear) begin
      w_entry_next = '0;
    end else if (r_state == ST_ENTRY && wr_en) begin
      w_entry_next[wr_loc] = wr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_entry_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Display digits. In ENTRY the post-write entry value is loaded so a write
  // shows one cycle later. RUN loads the counter every cycle, which also
  // captures the final count on the edge that samples finish. FINISHED holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dig_next = r_dig;
    if (clear) begin
      w_dig_next = '0;
    end else begin
      case (r_state)
        ST_ENTRY: w_dig_next = w_entry_next;
        ST_RUN:   w_dig_next = counter;
        ST_FIN:   w_dig_next = r_dig;
        default:  w_dig_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig <= '0;
    end else begin
      r_dig <= w_dig_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink generation
  // ---------------------------------------------------------------------------
`ifdef DISP_BLINK_EN
  localparam int                CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_on;

  // The counter only runs while staying in FINISHED; the entering edge and
  // any other phase hold it at zero with the display lit, so the first
  // visible period is a full BLINK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else if (r_state == ST_FIN && w_state_next == ST_FIN) begin
      if (r_blink_cnt == CNT_MAX) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end else begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
    end
  end

  assign blank = {4{r_blink_on}};
`else
  // Steady display; BLINK_DIV has no hardware to size.
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV < 2);
  assign blank = 4'b0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mode   = r_state;
  assign target = r_entry;
  assign dig0   = r_dig[0];
  assign dig1   = r_dig[1];
  assign dig2   = r_dig[2];
  assign dig3   = r_dig[3];

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_mode_ctrl
//
// Bench for disp_mode_ctrl with BLINK_DIV = 4. A table of single-cycle
// vectors walks the entry/run/finish/clear story with fixed expectations,
// hand sequences cover blinking, clear-vs-write and asynchronous reset, and a
// random phase is compared each cycle with a phase-level reference model.
// Works with or without DISP_BLINK_EN defined.
// -----------------------------------------------------------------------------
module tb_disp_mode_ctrl;

  localparam int BLINK_DIV = 4;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_loc = '0;
  logic [3:0]  wr_value = '0;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] counter = '0;
  logic [3:0]  dig0, dig1, dig2, dig3, blank;
  logic [1:0]  mode;
  logic [15:0] target;

  always #5 clk = ~clk;

  disp_mode_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_loc(wr_loc),
    .wr_value(wr_value), .start(start), .finish(finish), .clear(clear),
    .counter(counter), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blank(blank), .mode(mode), .target(target)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus / vector types
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        wr_en;
    logic [1:0]  loc;
    logic [3:0]  val;
    logic        start;
    logic        finish;
    logic        clear;
    logic [15:0] counter;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [1:0]  exp_mode;
    logic [15:0] exp_target;
    logic [15:0] exp_digs;   // {dig3,dig2,dig1,dig0}
    logic [3:0]  exp_blank;
  } vec_t;

  function automatic stim_t mk(logic we, logic [1:0] l, logic [3:0] v,
                               logic st, logic fi, logic cl, logic [15:0] c);
    stim_t s;
    s.wr_en = we; s.loc = l; s.val = v;
    s.start = st; s.finish = fi; s.clear = cl; s.counter = c;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: phase, entry digits, shown digits and time spent in
  // FINISHED. Blank is derived from elapsed FINISHED cycles by division.
  // ---------------------------------------------------------------------------
  logic [1:0] m_mode;
  logic [3:0] m_entry [4];
  logic [3:0] m_dig [4];
  int         m_fin_k;

  task automatic model_reset();
    m_mode = 2'b00;
    m_fin_k = 0;
    for (int i = 0; i < 4; i++) begin
      m_entry[i] = '0;
      m_dig[i] = '0;
    end
  endtask

  task automatic model_step(stim_t s);
    logic [1:0] old;
    old = m_mode;
    if (s.clear) begin
      for (int i = 0; i < 4; i++) begin
        m_entry[i] = '0;
        m_dig[i] = '0;
      end
      m_mode = 2'b00;
    end else if (old == 2'b00) begin
      if (s.wr_en) m_entry[s.loc] = s.val;
      for (int i = 0; i < 4; i++) m_dig[i] = m_entry[i];
      if (s.start) m_mode = 2'b01;
    end else if (old == 2'b01) begin
      for (int i = 0; i < 4; i++) m_dig[i] = s.counter[4*i +: 4];
      if (s.finish) m_mode = 2'b10;
    end
    m_fin_k = (old == 2'b10 && m_mode == 2'b10) ? m_fin_k + 1 : 0;
  endtask

  function automatic logic [3:0] model_blank();
    if (BLINK_EN && m_mode == 2'b10 && ((m_fin_k / BLINK_DIV) % 2 == 1))
      return 4'hF;
    return 4'h0;
  endfunction

  task automatic check_model(string tag);
    check({tag, ".mode"},   {14'd0, mode}, {14'd0, m_mode});
    check({tag, ".target"}, target, {m_entry[3], m_entry[2], m_entry[1], m_entry[0]});
    check({tag, ".digs"},   {dig3, dig2, dig1, dig0}, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    check({tag, ".blank"},  {12'd0, blank}, {12'd0, model_blank()});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of stimulus away from the edge, step the model on
  // the edge, leave the caller 1 time unit after the edge to sample.
  // ---------------------------------------------------------------------------
  task automatic drive(stim_t s);
    @(negedge clk);
    wr_en = s.wr_en; wr_loc = s.loc; wr_value = s.val;
    start = s.start; finish = s.finish; clear = s.clear; counter = s.counter;
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  vec_t vecs [16];

  initial begin
    // Directed table, expectations written from the phase rules.
    vecs[0]  = '{mk(1,0,4'h3,0,0,0,16'h0000), 2'b00, 16'h0003, 16'h0003, 4'h0};
    vecs[1]  = '{mk(1,1,4'hA,0,0,0,16'h0000), 2'b00, 16'h00A3, 16'h00A3, 4'h0};
    vecs[2]  = '{mk(1,2,4'h0,0,0,0,16'h0000), 2'b00, 16'h00A3, 16'h00A3, 4'h0};
    vecs[3]  = '{mk(1,3,4'h7,0,0,0,16'h0000), 2'b00, 16'h70A3, 16'h70A3, 4'h0};
    vecs[4]  = '{mk(1,0,4'h5,1,0,0,16'h1234), 2'b01, 16'h70A5, 16'h70A5, 4'h0};
    vecs[5]  = '{mk(1,1,4'hF,0,0,0,16'h1234), 2'b01, 16'h70A5, 16'h1234, 4'h0};
    vecs[6]  = '{mk(0,0,4'h0,1,0,0,16'hBEEF), 2'b01, 16'h70A5, 16'hBEEF, 4'h0};
    vecs[7]  = '{mk(0,0,4'h0,0,1,0,16'hBEEF), 2'b10, 16'h70A5, 16'hBEEF, 4'h0};
    vecs[8]  = '{mk(0,0,4'h0,0,0,0,16'h0000), 2'b10, 16'h70A5, 16'hBEEF, 4'h0};
    vecs[9]  = '{mk(1,2,4'h1,1,1,0,16'h0000), 2'b10, 16'h70A5, 16'hBEEF, 4'h0};
    vecs[10] = '{mk(0,0,4'h0,1,0,1,16'h0000), 2'b00, 16'h0000, 16'h0000, 4'h0};
    vecs[11] = '{mk(0,0,4'h0,0,1,0,16'h0000), 2'b00, 16'h0000, 16'h0000, 4'h0};
    vecs[12] = '{mk(1,2,4'h9,0,0,0,16'h4444), 2'b00, 16'h0900, 16'h0900, 4'h0};
    vecs[13] = '{mk(0,0,4'h0,1,0,0,16'h4444), 2'b01, 16'h0900, 16'h0900, 4'h0};
    vecs[14] = '{mk(0,0,4'h0,1,0,0,16'h5678), 2'b01, 16'h0900, 16'h5678, 4'h0};
    vecs[15] = '{mk(0,0,4'h0,0,0,1,16'h5678), 2'b00, 16'h0000, 16'h0000, 4'h0};

    // Reset state
    model_reset();
    #12;
    check("rst.mode",   {14'd0, mode}, 16'h0000);
    check("rst.target", target, 16'h0000);
    check("rst.digs",   {dig3, dig2, dig1, dig0}, 16'h0000);
    check("rst.blank",  {12'd0, blank}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].s);
      check($sformatf("vec%0d.mode", i),   {14'd0, mode}, {14'd0, vecs[i].exp_mode});
      check($sformatf("vec%0d.target", i), target, vecs[i].exp_target);
      check($sformatf("vec%0d.digs", i),   {dig3, dig2, dig1, dig0}, vecs[i].exp_digs);
      check($sformatf("vec%0d.blank", i),  {12'd0, blank}, {12'd0, vecs[i].exp_blank});
    end

    // FINISHED: digits frozen on the finish-edge count, blank follows elapsed
    // time (blinks only when the feature is built in).
    drive(mk(1, 3, 4'hC, 0, 0, 0, 16'h0000));
    drive(mk(0, 0, 4'h0, 1, 0, 0, 16'h0000));
    drive(mk(0, 0, 4'h0, 0, 0, 0, 16'h1111));
    drive(mk(0, 0, 4'h0, 0, 1, 0, 16'h4321));
    check_model("fin_enter");
    for (int k = 1; k <= 20; k++) begin
      drive(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
               16'($urandom_range(0, 65535))));
      check($sformatf("fin%0d.digs", k), {dig3, dig2, dig1, dig0}, 16'h4321);
      check($sformatf("fin%0d.blank", k), {12'd0, blank},
            (BLINK_EN && ((k / BLINK_DIV) % 2 == 1)) ? 16'h000F : 16'h0000);
      check($sformatf("fin%0d.target", k), target, 16'hC000);
    end

    // clear beats a simultaneous write
    drive(mk(1, 1, 4'h6, 0, 0, 1, 16'h0000));
    check("clr_wr.target", target, 16'h0000);
    check_model("clr_wr");

    // Asynchronous reset mid-RUN, between edges
    drive(mk(1, 0, 4'h8, 1, 0, 0, 16'h0000));
    drive(mk(0, 0, 4'h0, 0, 0, 0, 16'h9999));
    check("run.digs", {dig3, dig2, dig1, dig0}, 16'h9999);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.mode",   {14'd0, mode}, 16'h0000);
    check("arst.target", target, 16'h0000);
    check("arst.digs",   {dig3, dig2, dig1, dig0}, 16'h0000);
    check("arst.blank",  {12'd0, blank}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 4'h0, 0, 1, 0, 16'hFFFF));
    check("arst_fin.mode", {14'd0, mode}, 16'h0000);
    check_model("arst_fin");

    // Randomized phase against the model
    for (int i = 0; i < 400; i++) begin
      drive(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 23) == 0), 16'($urandom_range(0, 65535))));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
